// File: rtl/riscv_mem_responder.sv
// Memory responder for the core boundary bus: 1-cycle fetch port plus
// a latency-programmable data port. Optional: RISCV_MEM_MISALIGN_CHECK_EN.
module riscv_mem_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_address,
    input  logic        instruction_enable,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic [31:0] address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enables,
    output logic [31:0] read_data,
    output logic        result_valid,
    output logic        busy,
    output logic        misaligned
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    logic [31:0] code_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              wr_q;
    logic              mis_q;
    logic              req;
    logic              mis_req;

    logic              f_vld_q;
    logic [ADDR_W-1:0] f_idx_q;

    assign req = read_enable | write_enable;

`ifdef RISCV_MEM_MISALIGN_CHECK_EN
    logic unused_bits;
    assign unused_bits = ^{instruction_address[31:ADDR_W+2],
                           instruction_address[1:0],
                           address[31:ADDR_W+2]};

    // Loads and full-word stores need word alignment; halfword
    // stores must not sit on an odd byte.
    always_comb begin
        mis_req = 1'b0;
        if (address[1:0] != 2'b00 &&
            (!write_enable || byte_enables == 4'b1111))
            mis_req = 1'b1;
        if (write_enable && address[0] &&
            (byte_enables == 4'b0011 || byte_enables == 4'b1100))
            mis_req = 1'b1;
    end
`else
    logic unused_bits;
    assign unused_bits = ^{instruction_address[31:ADDR_W+2],
                           instruction_address[1:0],
                           address[31:ADDR_W+2],
                           address[1:0]};
    assign mis_req = 1'b0;
`endif

    // Fetch port: capture the request, then return the word next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_vld_q     <= 1'b0;
            f_idx_q     <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            f_vld_q     <= instruction_enable;
            if (instruction_enable)
                f_idx_q <= instruction_address[ADDR_W+1:2];
            instr_valid <= f_vld_q;
            if (f_vld_q)
                instr <= code_mem[f_idx_q];
        end
    end

    // Data port FSM: accept, count down the latency, respond once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            wr_q         <= 1'b0;
            mis_q        <= 1'b0;
            read_data    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            misaligned   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            misaligned   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= address[ADDR_W+1:2];
                        wdata_q <= write_data;
                        be_q    <= byte_enables;
                        wr_q    <= write_enable;
                        mis_q   <= mis_req;
                        cnt     <= 4'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    result_valid <= 1'b1;
                    misaligned   <= mis_q;
                    read_data    <= mis_q ? 32'h0 : data_mem[idx_q];
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store commit on the response edge; the read above sees the old word.
    always_ff @(posedge clk) begin
        if (rst && state == RESP && wr_q && !mis_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i])
                    data_mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench for riscv_mem_responder: LATENCY=3 main instance and
// a LATENCY=4 instance used for the mid-request reset case.
module tb_riscv_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst4;
    logic [31:0] ia;
    logic        ie;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  be;

    logic [31:0] instr, read_data;
    logic        instr_valid, result_valid, busy, misaligned;
    logic [31:0] instr_4, read_data_4;
    logic        instr_valid_4, result_valid_4, busy_4, misaligned_4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_mem_responder #(.ADDR_W(16), .LATENCY(3)) u_dut (
        .clk(clk), .rst(rst),
        .instruction_address(ia), .instruction_enable(ie),
        .instr(instr), .instr_valid(instr_valid),
        .address(addr), .read_enable(re), .write_enable(we),
        .write_data(wd), .byte_enables(be),
        .read_data(read_data), .result_valid(result_valid),
        .busy(busy), .misaligned(misaligned)
    );

    riscv_mem_responder #(.ADDR_W(16), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst4),
        .instruction_address(ia), .instruction_enable(ie),
        .instr(instr_4), .instr_valid(instr_valid_4),
        .address(addr), .read_enable(re), .write_enable(we),
        .write_data(wd), .byte_enables(be),
        .read_data(read_data_4), .result_valid(result_valid_4),
        .busy(busy_4), .misaligned(misaligned_4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dreq(input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int lat,
                        output logic [31:0] rd, output logic mis);
        re = r; we = w; addr = a; wd = d; be = m;
        tick;
        re = 1'b0; we = 1'b0;
        lat = 0;
        while (!result_valid && lat < 20) begin
            tick;
            lat++;
        end
        rd  = read_data;
        mis = misaligned;
    endtask

    int          lat;
    int          pulses;
    logic [31:0] rd;
    logic        mis;

    initial begin
        rst = 1'b0; rst4 = 1'b0;
        ia = '0; ie = 1'b0; addr = '0; re = 1'b0; we = 1'b0;
        wd = '0; be = '0;
        tick; tick;
        chk("rst_instr", instr, 32'h0);
        chk("rst_ivalid", {31'b0, instr_valid}, 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_rvalid", {31'b0, result_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_mis", {31'b0, misaligned}, 32'h0);
        rst = 1'b1;
        tick;

        u_dut.code_mem[4] = 32'h00500093;
        u_dut.code_mem[5] = 32'h00100113;
        ia = 32'h10; ie = 1'b1;
        tick;
        ia = 32'h14;
        tick;
        chk("fetch0_valid", {31'b0, instr_valid}, 32'h1);
        chk("fetch0_instr", instr, 32'h00500093);
        ie = 1'b0;
        tick;
        chk("fetch1_valid", {31'b0, instr_valid}, 32'h1);
        chk("fetch1_instr", instr, 32'h00100113);
        tick;
        chk("fetch_idle_valid", {31'b0, instr_valid}, 32'h0);
        chk("fetch_hold_instr", instr, 32'h00100113);

        dreq(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, lat, rd, mis);
        chk("st_latency", 32'(lat), 32'd3);
        chk("st_mem", u_dut.data_mem[64], 32'hDEADBEEF);
        tick;
        chk("st_pulse_end", {31'b0, result_valid}, 32'h0);
        dreq(1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, lat, rd, mis);
        chk("ld_latency", 32'(lat), 32'd3);
        chk("ld_data", rd, 32'hDEADBEEF);
        tick;

        u_dut.data_mem[1] = 32'h11223344;
        dreq(1'b0, 1'b1, 32'h4, 32'hAA000000, 4'b1000, lat, rd, mis);
        chk("sb_rdata_old", rd, 32'h11223344);
        chk("sb_mem", u_dut.data_mem[1], 32'hAA223344);
        tick;
        dreq(1'b0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'b0000, lat, rd, mis);
        chk("be0_latency", 32'(lat), 32'd3);
        chk("be0_mem", u_dut.data_mem[1], 32'hAA223344);
        tick;
        u_dut.data_mem[3] = 32'h0;
        dreq(1'b1, 1'b1, 32'hC, 32'h12345678, 4'b1111, lat, rd, mis);
        chk("rw_rdata_old", rd, 32'h0);
        chk("rw_mem", u_dut.data_mem[3], 32'h12345678);
        tick;
        dreq(1'b1, 1'b0, 32'h0004_0100, 32'h0, 4'b0000, lat, rd, mis);
        chk("wrap_ld", rd, 32'hDEADBEEF);
        tick;

        u_dut.data_mem[2] = 32'h55667788;
        re = 1'b1; addr = 32'h100;
        tick;
        re = 1'b0;
        we = 1'b1; addr = 32'h8; wd = 32'h0; be = 4'b1111;
        chk("busy_high", {31'b0, busy}, 32'h1);
        pulses = 0;
        tick;
        if (result_valid) pulses++;
        tick;
        if (result_valid) pulses++;
        we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (result_valid) pulses++;
        end
        chk("busy_pulses", 32'(pulses), 32'd1);
        chk("busy_mem", u_dut.data_mem[2], 32'h55667788);

        dreq(1'b1, 1'b0, 32'h102, 32'h0, 4'b0000, lat, rd, mis);
        chk("mis_ld_latency", 32'(lat), 32'd3);
`ifdef RISCV_MEM_MISALIGN_CHECK_EN
        chk("mis_ld_flag", {31'b0, mis}, 32'h1);
        chk("mis_ld_data", rd, 32'h0);
`else
        chk("mis_ld_flag", {31'b0, mis}, 32'h0);
        chk("mis_ld_data", rd, 32'hDEADBEEF);
`endif
        tick;
        u_dut.data_mem[65] = 32'h0;
        dreq(1'b0, 1'b1, 32'h105, 32'h0000BEEF, 4'b0011, lat, rd, mis);
`ifdef RISCV_MEM_MISALIGN_CHECK_EN
        chk("mis_sh_flag", {31'b0, mis}, 32'h1);
        chk("mis_sh_mem", u_dut.data_mem[65], 32'h0);
`else
        chk("mis_sh_flag", {31'b0, mis}, 32'h0);
        chk("mis_sh_mem", u_dut.data_mem[65], 32'h0000BEEF);
`endif
        tick;
        dreq(1'b0, 1'b1, 32'h106, 32'hCAFE0000, 4'b1100, lat, rd, mis);
        chk("al_sh_flag", {31'b0, mis}, 32'h0);
`ifdef RISCV_MEM_MISALIGN_CHECK_EN
        chk("al_sh_mem", u_dut.data_mem[65], 32'hCAFE0000);
`else
        chk("al_sh_mem", u_dut.data_mem[65], 32'hCAFEBEEF);
`endif
        tick;

        rst4 = 1'b1;
        u_dut4.data_mem[8] = 32'h0BADF00D;
        tick;
        we = 1'b1; addr = 32'h20; wd = 32'hFFFFFFFF; be = 4'b1111;
        tick;
        we = 1'b0;
        chk("r4_busy", {31'b0, busy_4}, 32'h1);
        tick;
        tick;
        #2 rst4 = 1'b0;
        #1;
        chk("r4_instr", instr_4, 32'h0);
        chk("r4_ivalid", {31'b0, instr_valid_4}, 32'h0);
        chk("r4_rdata", read_data_4, 32'h0);
        chk("r4_rvalid", {31'b0, result_valid_4}, 32'h0);
        chk("r4_busy_rst", {31'b0, busy_4}, 32'h0);
        chk("r4_mis", {31'b0, misaligned_4}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i == 1) rst4 = 1'b1;
            if (result_valid_4) pulses++;
        end
        chk("r4_pulses", 32'(pulses), 32'd0);
        chk("r4_mem", u_dut4.data_mem[8], 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
